stream_sink_checker: RTL and testbench
======================================

Name: stream_sink_checker

Overview:
- Synthesizable consumer end of the team's valid/ready byte-stream interface. It pairs with the sender and sits downstream of any handshake bridge under test.
- Each cycle it drives a pseudo-random, throttled ready. It accepts beats, checks them against an expected incrementing sequence, and counts beats and errors.
- It raises done after a programmed number of beats. It serves as an on-chip/FPGA replacement for the behavioural receiver plus scoreboard.

Parameters:
- DATA_W, 8, width of data_i and of the expected-value register.
- START_VAL, 1, first expected data value after reset.
- BEAT_TARGET, 200, number of accepted beats after which the checker enters DONE (must be ≥1).
- CNT_W, 16, width of the beat and error counters.
- LFSR_SEED, 16'hACE1, reset value of the ready-generation LFSR (must be non-zero).

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  reset, asynchronous, active-high
- enable_i  input  1  run request; while low the checker holds its state and accepts nothing
- throttle_i  input  2  ready density: 0=100%, 1=75%, 2=50%, 3=25%
- valid_i  input  1  upstream valid
- data_i  input  DATA_W  upstream data, sampled on handshake
- ready_o  output  1  registered ready to upstream
- beat_cnt_o  output  CNT_W  accepted beats since reset
- err_cnt_o  output  CNT_W  mismatching beats, saturating at all-ones
- err_o  output  1  sticky, set on first mismatch
- first_err_data_o  output  DATA_W  data_i of first mismatch
- first_err_exp_o  output  DATA_W  expected value at first mismatch
- done_o  output  1  high in DONE state

Behaviour:
- Reset (reset_n=1, asynchronous):
  - state=IDLE, ready_o=0, beat_cnt_o=0, err_cnt_o=0, err_o=0, done_o=0.
  - first_err_*=0, expected=START_VAL, LFSR=LFSR_SEED.
  - Reset asserted mid-run clears everything immediately, without waiting for a clock edge.
- Handshake: a beat is accepted on a rising edge where valid_i & ready_o. ready_o is a flop with no combinational path from valid_i or data_i. ready_o may toggle freely regardless of valid_i.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances on every clock in RUN only and holds in IDLE and DONE.
- Next ready in RUN is a function of the next LFSR value L:
  - throttle 0 → 1
  - throttle 1 → L[1:0]!=0
  - throttle 2 → L[0]
  - throttle 3 → L[1:0]==0
  - throttle_i is sampled every cycle; a change takes effect on the next ready_o update.
- State machine:
  - IDLE: ready_o=0. When enable_i=1, move to RUN; ready_o may first rise in the cycle after entry.
  - RUN: generate ready as above. On each accepted beat, evaluate the beat checks below.
    - If enable_i=0, go to IDLE with ready_o=0 next cycle. Counters, expected value and LFSR hold.
    - When the accepted beat makes beat_cnt reach BEAT_TARGET, go to DONE.
  - DONE: ready_o=0, done_o=1. Stays in DONE until reset; enable_i is ignored.
- Beat check on each accepted beat:
  - beat_cnt += 1; it wraps at 2^CNT_W but never reaches that in practice.
  - If data_i == expected: expected = expected+1 mod 2^DATA_W.
  - Else: err_cnt += 1 (saturating). If err_o was 0, set err_o and capture first_err_data_o=data_i and first_err_exp_o=expected. Resync expected = data_i+1 mod 2^DATA_W, so one discontinuity counts as one error.
- Simultaneous events:
  - The beat that reaches BEAT_TARGET is still checked and counted.
  - If enable_i falls on the same edge as a handshake, that beat is accepted, then the checker goes to IDLE.
- Wrap-around: expected 2^DATA_W-1 is followed by 0; this is not an error.
- Latency: err_o, counters and done_o update on the edge that accepts the beat (visible the same cycle after the edge).

Test Plan:
- Full-rate run: throttle 0, enable=1, source valid always high with data 1,2,…,200.
  - ready_o=1 from the 2nd RUN cycle.
  - done_o=1 after exactly 200 handshakes; beat_cnt_o=200, err_cnt_o=0, err_o=0; ready_o=0 thereafter.
- Mismatch and resync: data sequence 1,2,3,7,8,9.
  - err_cnt_o=1, err_o=1, first_err_data_o=7, first_err_exp_o=4.
  - Beats 8 and 9 do not raise the count.
  - A second gap (9 then 20) gives err_cnt_o=2 with first_err_* unchanged.
- Wrap: START_VAL=250, data 250..255,0,1,2 → err_cnt_o=0, beat_cnt_o=9.
- Throttle density: throttle 3, valid held high for 1024 RUN cycles.
  - Accepted beats must be between 200 and 312.
  - Repeat with throttle 2 (bounds 448–576) and throttle 1 (704–832).
- Enable drop and mid-run reset:
  - Deassert enable_i at beat 50 → ready_o=0 next cycle and beat_cnt_o holds at 50 across 20 cycles of valid high. Re-enable → the next beat expected is 51.
  - Then assert reset_n=1 between clock edges → all outputs reach reset values before the next rising edge.

Source files
------------

// File: rtl/stream_sink_checker.sv
// stream_sink_checker: throttled-ready stream sink that checks an incrementing data sequence,
// counts beats and errors, and raises done after a programmed number of beats.
module stream_sink_checker #(
  parameter int          DATA_W      = 8,
  parameter int          START_VAL   = 1,
  parameter int          BEAT_TARGET = 200,
  parameter int          CNT_W       = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic [1:0]        throttle_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              err_o,
  output logic [DATA_W-1:0] first_err_data_o,
  output logic [DATA_W-1:0] first_err_exp_o,
  output logic              done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0]  TARGET = CNT_W'(BEAT_TARGET);
  localparam logic [DATA_W-1:0] START  = DATA_W'(START_VAL);
  state_t            state_q, state_d;
  logic              ready_q, ready_d, err_q, err_d, done_q, done_d, accept, miss;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d, err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] exp_q, exp_d, first_data_q, first_data_d, first_exp_q, first_exp_d;
  always_comb begin
    accept       = state_q == RUN && valid_i && ready_q;
    miss         = accept && data_i != exp_q;
    lfsr_d       = state_q == RUN ? {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000) : lfsr_q;
    beat_cnt_d   = accept ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
    err_cnt_d    = miss && !(&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    err_d        = err_q || miss;
    first_data_d = miss && !err_q ? data_i : first_data_q;
    first_exp_d  = miss && !err_q ? exp_q : first_exp_q;
    // on a match data_i equals exp_q, so data_i+1 serves both advance and resync
    exp_d        = accept ? data_i + DATA_W'(1) : exp_q;
    state_d      = state_q == IDLE ? (enable_i ? RUN : IDLE)
                 : state_q == RUN  ? (accept && beat_cnt_d == TARGET ? DONE : enable_i ? RUN : IDLE)
                 : DONE;
    ready_d      = state_q == RUN && state_d == RUN &&
                   (throttle_i == 2'd0 ? 1'b1 : throttle_i == 2'd1 ? |lfsr_d[1:0] :
                    throttle_i == 2'd2 ? lfsr_d[0] : ~|lfsr_d[1:0]);
    done_d       = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      beat_cnt_q   <= '0;
      err_cnt_q    <= '0;
      exp_q        <= START;
      first_data_q <= '0;
      first_exp_q  <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      lfsr_q       <= lfsr_d;
      beat_cnt_q   <= beat_cnt_d;
      err_cnt_q    <= err_cnt_d;
      exp_q        <= exp_d;
      first_data_q <= first_data_d;
      first_exp_q  <= first_exp_d;
    end
  end
  assign ready_o          = ready_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign beat_cnt_o       = beat_cnt_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_data_o = first_data_q;
  assign first_err_exp_o  = first_exp_q;
endmodule

// File: tb/tb_stream_sink_checker.sv
// tb_stream_sink_checker: two checker instances (default, and wrap-start with a long target)
// driven by directed and random stimulus, compared every cycle against a behavioural model.
module tb_stream_sink_checker;
  localparam int SV[2] = '{1, 250};
  localparam int TG[2] = '{200, 3000};
  typedef struct {
    bit run, done, rdy, err;
    logic [15:0] lfsr;
    int beats, errs, exp, fd, fe;
  } mdl_t;
  logic clk = 0, reset_n = 1, enable = 0, chk_en = 0;
  logic [1:0] throttle = 0;
  logic vld[2], rdy[2], err[2], done[2];
  logic [7:0] dat[2], fd[2], fe[2];
  logic [15:0] bc[2], ec[2];
  mdl_t m[2];
  int sent[2];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  stream_sink_checker dut0 (
    .clk(clk), .reset_n(reset_n), .enable_i(enable), .throttle_i(throttle),
    .valid_i(vld[0]), .data_i(dat[0]), .ready_o(rdy[0]), .beat_cnt_o(bc[0]),
    .err_cnt_o(ec[0]), .err_o(err[0]), .first_err_data_o(fd[0]),
    .first_err_exp_o(fe[0]), .done_o(done[0]));
  stream_sink_checker #(.START_VAL(250), .BEAT_TARGET(3000)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable_i(enable), .throttle_i(throttle),
    .valid_i(vld[1]), .data_i(dat[1]), .ready_o(rdy[1]), .beat_cnt_o(bc[1]),
    .err_cnt_o(ec[1]), .err_o(err[1]), .first_err_data_o(fd[1]),
    .first_err_exp_o(fe[1]), .done_o(done[1]));
  function automatic bit dens(logic [15:0] l, logic [1:0] t);
    int q = int'(l) % 4;
    return t == 2'd0 ? 1'b1 : t == 2'd1 ? q != 0 : t == 2'd2 ? q % 2 == 1 : q == 0;
  endfunction
  function automatic mdl_t init(int sv);
    mdl_t n;
    n.run = 0; n.done = 0; n.rdy = 0; n.err = 0; n.lfsr = 16'hACE1;
    n.beats = 0; n.errs = 0; n.exp = sv; n.fd = 0; n.fe = 0;
    return n;
  endfunction
  function automatic mdl_t step(mdl_t s, int tg, bit en, logic [1:0] t, bit v, int d);
    mdl_t n = s;
    bit acc;
    if (s.done) return n;
    if (!s.run) begin
      n.run = en;
      return n;
    end
    n.lfsr = s.lfsr[0] ? (s.lfsr >> 1) ^ 16'hB400 : s.lfsr >> 1;
    acc = v && s.rdy;
    if (acc) begin
      n.beats++;
      if (d == s.exp) n.exp = (s.exp + 1) % 256;
      else begin
        if (n.errs < 65535) n.errs++;
        if (!s.err) begin n.err = 1; n.fd = d; n.fe = s.exp; end
        n.exp = (d + 1) % 256;
      end
    end
    n.done = acc && n.beats == tg;
    n.run = !n.done && en;
    n.rdy = n.run && dens(n.lfsr, t);
    return n;
  endfunction
  always @(posedge clk or posedge reset_n)
    for (int i = 0; i < 2; i++)
      if (reset_n) m[i] <= init(SV[i]);
      else m[i] <= step(m[i], TG[i], enable, throttle, vld[i], 32'(dat[i]));
  task automatic cmp(string nm, int i, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d, want %0d at %0t", nm, i, act, exp, $time);
  endtask
  task automatic cmp_range(string nm, int act, int lo, int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
  endtask
  always @(negedge clk)
    if (chk_en)
      for (int i = 0; i < 2; i++) begin
        cmp("ready_o", i, 32'(rdy[i]), 32'(m[i].rdy));
        cmp("beat_cnt_o", i, 32'(bc[i]), m[i].beats % 65536);
        cmp("err_cnt_o", i, 32'(ec[i]), m[i].errs);
        cmp("err_o", i, 32'(err[i]), 32'(m[i].err));
        cmp("first_err_data_o", i, 32'(fd[i]), m[i].fd);
        cmp("first_err_exp_o", i, 32'(fe[i]), m[i].fe);
        cmp("done_o", i, 32'(done[i]), 32'(m[i].done));
      end
  task automatic tick();
    bit hs[2];
    for (int i = 0; i < 2; i++) hs[i] = vld[i] && rdy[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (hs[i]) begin
        sent[i]++;
        dat[i] = dat[i] + 8'd1;
      end
  endtask
  task automatic run_until(int i, int n, int bound);
    for (int k = 0; k < bound && sent[i] < n; k++) tick();
    cmp("beats_reached", i, sent[i], n);
  endtask
  task automatic mid_reset(int d);
    #(d);
    reset_n = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp("rst_ready", i, 32'(rdy[i]), 0);
      cmp("rst_beats", i, 32'(bc[i]), 0);
      cmp("rst_errs", i, 32'(ec[i]), 0);
      cmp("rst_err", i, 32'(err[i]), 0);
      cmp("rst_done", i, 32'(done[i]), 0);
      cmp("rst_fd", i, 32'(fd[i]), 0);
    end
    @(posedge clk);
    #1;
    reset_n = 0;
    for (int i = 0; i < 2; i++) begin
      sent[i] = 0;
      dat[i] = 8'(SV[i]);
    end
  endtask
  initial begin
    int s0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 0;
      dat[i] = 8'(SV[i]);
      sent[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    cmp("reset_ready", 0, 32'(rdy[0]), 0);
    cmp("reset_beats", 0, 32'(bc[0]), 0);
    reset_n = 0;
    throttle = 0;
    enable = 1;
    vld[0] = 1;
    vld[1] = 1;
    tick();
    cmp("ready_first_run", 0, 32'(rdy[0]), 0);
    tick();
    cmp("ready_second_run", 0, 32'(rdy[0]), 1);
    run_until(0, 200, 400);
    cmp("full_done", 0, 32'(done[0]), 1);
    cmp("full_beats", 0, 32'(bc[0]), 200);
    cmp("full_errs", 0, 32'(ec[0]), 0);
    cmp("full_err", 0, 32'(err[0]), 0);
    repeat (3) tick();
    cmp("done_ready", 0, 32'(rdy[0]), 0);
    cmp("done_beats_hold", 0, 32'(bc[0]), 200);
    mid_reset(1);
    run_until(0, 3, 20);
    dat[0] = 8'd7;
    run_until(0, 6, 20);
    cmp("gap1_errs", 0, 32'(ec[0]), 1);
    cmp("gap1_err", 0, 32'(err[0]), 1);
    cmp("gap1_fd", 0, 32'(fd[0]), 7);
    cmp("gap1_fe", 0, 32'(fe[0]), 4);
    dat[0] = 8'd20;
    run_until(0, 7, 20);
    cmp("gap2_errs", 0, 32'(ec[0]), 2);
    cmp("gap2_fd", 0, 32'(fd[0]), 7);
    cmp("gap2_fe", 0, 32'(fe[0]), 4);
    run_until(1, 9, 20);
    cmp("wrap_beats", 1, 32'(bc[1]), 9);
    cmp("wrap_errs", 1, 32'(ec[1]), 0);
    for (int t = 3; t >= 1; t--) begin
      mid_reset(2);
      throttle = 2'(t);
      tick();
      s0 = sent[1];
      repeat (1024) tick();
      if (t == 3) cmp_range("density_t3", sent[1] - s0, 200, 312);
      if (t == 2) cmp_range("density_t2", sent[1] - s0, 448, 576);
      if (t == 1) cmp_range("density_t1", sent[1] - s0, 704, 832);
    end
    mid_reset(1);
    throttle = 0;
    run_until(0, 49, 100);
    enable = 0;
    tick();
    cmp("drop_beats", 0, 32'(bc[0]), 50);
    cmp("drop_ready", 0, 32'(rdy[0]), 0);
    repeat (20) tick();
    cmp("drop_hold", 0, 32'(bc[0]), 50);
    enable = 1;
    run_until(0, 51, 20);
    cmp("resume_beats", 0, 32'(bc[0]), 51);
    cmp("resume_errs", 0, 32'(ec[0]), 0);
    for (int k = 0; k < 4000; k++) begin
      if (k % 700 == 699) mid_reset($urandom_range(1, 2));
      if ($urandom_range(15) == 0) throttle = 2'($urandom_range(3));
      if ($urandom_range(63) == 0) enable = 0;
      else if ($urandom_range(7) == 0) enable = 1;
      for (int i = 0; i < 2; i++) begin
        vld[i] = $urandom_range(3) != 0;
        if ($urandom_range(39) == 0) dat[i] = dat[i] + 8'($urandom_range(2, 60));
      end
      tick();
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
